// File: rtl/z3_slave_cycle_engine_if.sv
// Zorro III slave cycle bus bundle: synchronised bus qualifiers and region
// handshakes in, cycle status and DTACK request out.
interface z3_slave_cycle_engine_if #(
  parameter int NUM_REGIONS = 4
);
  logic                   bfcs;
  logic                   match;
  logic                   validspace;
  logic                   READ;
  logic [3:0]             DS_n;
  logic [NUM_REGIONS-1:0] region_sel;
  logic [NUM_REGIONS-1:0] region_ack;
  logic [NUM_REGIONS-1:0] region_req;
  logic [NUM_REGIONS-1:0] cycle_sel;
  logic                   dtack;
  logic                   timeout_err;
  logic                   busy;
  logic [2:0]             z3_state;

  modport slave (
    input  bfcs, match, validspace, READ, DS_n, region_sel, region_ack,
    output region_req, cycle_sel, dtack, timeout_err, busy, z3_state
  );

  modport master (
    output bfcs, match, validspace, READ, DS_n, region_sel, region_ack,
    input  region_req, cycle_sel, dtack, timeout_err, busy, z3_state
  );
endinterface

// File: rtl/z3_slave_cycle_engine.sv
// Zorro III slave cycle engine: IDLE/START/DATA/WAIT/END sequencing, lowest-
// index region priority, ack-to-DTACK wait states and registered outputs.
// Optional bus-timeout abort is enabled by defining Z3_SLAVE_TIMEOUT_EN.
module z3_slave_cycle_engine #(
  parameter int NUM_REGIONS    = 4,
  parameter int DTACK_DELAY    = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RESET,
  z3_slave_cycle_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_END   = 3'd4
  } state_t;

  if (NUM_REGIONS < 1 || NUM_REGIONS > 16 || DTACK_DELAY < 0 || DTACK_DELAY > 7 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("z3_slave_cycle_engine: parameter out of range");
  end

  // Wait-state counter is kept at least one bit wide so DTACK_DELAY=0 still elaborates.
  localparam int                WAIT_W    = (DTACK_DELAY > 0) ? $clog2(DTACK_DELAY + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (DTACK_DELAY > 0) ? WAIT_W'(DTACK_DELAY - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;

  state_t                  r_state;
  state_t                  w_next;
  logic [NUM_REGIONS-1:0]  r_cycle_sel;
  logic [NUM_REGIONS-1:0]  w_cycle_sel_nxt;
  logic [NUM_REGIONS-1:0]  r_region_req;
  logic                    r_dtack;
  logic                    r_busy;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic                    w_ack;

`ifdef Z3_SLAVE_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = '1;
  logic [TO_W-1:0]            r_to_cnt;
  logic                       r_timeout_err;
  logic                       w_to_fire;
`endif

  // Lowest-index set bit wins when several regions decode at once.
  function automatic logic [NUM_REGIONS-1:0] f_lowest(input logic [NUM_REGIONS-1:0] v);
    f_lowest = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        f_lowest    = '0;
        f_lowest[i] = 1'b1;
      end
    end
  endfunction

  // Next-state and next cycle_sel; bfcs loss always aborts to IDLE first.
  always_comb begin
    w_next          = r_state;
    w_cycle_sel_nxt = r_cycle_sel;
    w_ack           = |(bus.region_ack & r_cycle_sel);
`ifdef Z3_SLAVE_TIMEOUT_EN
    w_to_fire       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.bfcs && bus.match && bus.validspace && (|bus.region_sel)) begin
          w_next          = ST_START;
          w_cycle_sel_nxt = f_lowest(bus.region_sel);
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (!bus.bfcs) begin
          w_next          = ST_IDLE;
          w_cycle_sel_nxt = '0;
        end else if (bus.READ || (bus.DS_n != 4'hF)) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_START;
        end
      end
      ST_DATA: begin
        if (!bus.bfcs) begin
          w_next          = ST_IDLE;
          w_cycle_sel_nxt = '0;
        end else if (w_ack) begin
          if (DTACK_DELAY > 0) begin
            w_next = ST_WAIT;
          end else begin
            w_next = ST_END;
          end
`ifdef Z3_SLAVE_TIMEOUT_EN
        end else if (r_to_cnt == TO_LAST) begin
          w_next    = ST_END;
          w_to_fire = 1'b1;
`endif
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (!bus.bfcs) begin
          w_next          = ST_IDLE;
          w_cycle_sel_nxt = '0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next = ST_END;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_END: begin
        if (!bus.bfcs) begin
          w_next          = ST_IDLE;
          w_cycle_sel_nxt = '0;
        end else begin
          w_next = ST_END;
        end
      end
      default: begin
        w_next          = ST_IDLE;
        w_cycle_sel_nxt = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cycle_sel  <= '0;
      r_region_req <= '0;
      r_dtack      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cycle_sel  <= w_cycle_sel_nxt;
      r_region_req <= (w_next == ST_DATA) ? w_cycle_sel_nxt : '0;
      r_dtack      <= (w_next == ST_END);
      r_busy       <= (w_next != ST_IDLE);
    end
  end

  // Wait-state counter: clears on any state change, counts up in WAIT, saturates.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WAIT) && (r_wait_cnt != WAIT_SAT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

`ifdef Z3_SLAVE_TIMEOUT_EN
  // Timeout counter and sticky error flag held until END is left.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_DATA) && (r_to_cnt != TO_SAT)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      r_timeout_err <= (w_next == ST_END) ? (r_timeout_err | w_to_fire) : 1'b0;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.z3_state   = r_state;
  assign bus.cycle_sel  = r_cycle_sel;
  assign bus.region_req = r_region_req;
  assign bus.dtack      = r_dtack;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_z3_slave_cycle_engine.sv
// Bench for z3_slave_cycle_engine: two instances (DTACK_DELAY 0 and 3) share
// one stimulus stream; expectations come from per-transaction timelines built
// from the cycle rules (START/DATA/ack latency/bfcs abort/timeout).
module tb_z3_slave_cycle_engine;
  localparam int NR = 4;
  localparam int D3 = 3;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       bfcs, match, validspace, READ;
  logic [3:0] DS_n, region_sel, region_ack;
  int         n_total = 0;
  int         n_pass  = 0;

  always #5 CLK = ~CLK;

  z3_slave_cycle_engine_if #(.NUM_REGIONS(NR)) if_d0 ();
  z3_slave_cycle_engine_if #(.NUM_REGIONS(NR)) if_d3 ();

  assign if_d0.bfcs = bfcs;             assign if_d3.bfcs = bfcs;
  assign if_d0.match = match;           assign if_d3.match = match;
  assign if_d0.validspace = validspace; assign if_d3.validspace = validspace;
  assign if_d0.READ = READ;             assign if_d3.READ = READ;
  assign if_d0.DS_n = DS_n;             assign if_d3.DS_n = DS_n;
  assign if_d0.region_sel = region_sel; assign if_d3.region_sel = region_sel;
  assign if_d0.region_ack = region_ack; assign if_d3.region_ack = region_ack;

  z3_slave_cycle_engine #(.NUM_REGIONS(NR), .DTACK_DELAY(0), .TIMEOUT_CYCLES(TO)) u_d0 (
    .CLK(CLK), .RESET(RESET), .bus(if_d0));
  z3_slave_cycle_engine #(.NUM_REGIONS(NR), .DTACK_DELAY(D3), .TIMEOUT_CYCLES(TO)) u_d3 (
    .CLK(CLK), .RESET(RESET), .bus(if_d3));

  // observed = {state, cycle_sel, region_req, dtack, busy, timeout_err}
  logic [14:0] obs0, obs3;
  assign obs0 = {if_d0.z3_state, if_d0.cycle_sel, if_d0.region_req, if_d0.dtack, if_d0.busy, if_d0.timeout_err};
  assign obs3 = {if_d3.z3_state, if_d3.cycle_sel, if_d3.region_req, if_d3.dtack, if_d3.busy, if_d3.timeout_err};

  typedef struct packed {
    logic        rst;
    logic        b;
    logic [3:0]  sel;
    logic        rd;
    logic [3:0]  ds;
    logic [3:0]  ack;
    logic [14:0] e0;
    logic [14:0] e3;
  } step_t;

  step_t tl[$];

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
    return 4'h0;
  endfunction

  // Expected snapshot: region_req mirrors cycle_sel only in DATA, busy whenever not IDLE.
  function automatic logic [14:0] snap(input logic [2:0] st, input logic [3:0] cs, input logic dt, input logic te);
    return {st, cs, (st == 3'd2) ? cs : 4'h0, dt, (st != 3'd0), te};
  endfunction

  task automatic push(input logic rst, input logic b, input logic [3:0] sel, input logic rd,
                      input logic [3:0] ds, input logic [3:0] ack, input logic [14:0] e0, input logic [14:0] e3);
    step_t s;
    s.rst = rst; s.b = b; s.sel = sel; s.rd = rd; s.ds = ds; s.ack = ack; s.e0 = e0; s.e3 = e3;
    tl.push_back(s);
  endtask

  // abort: 0 none, 1 drop bfcs in START, 2 drop with the ack, 3 drop right after the ack.
  task automatic build_txn(input logic [3:0] sel, input logic rd, input int ds_wait, input int ack_wait,
                           input logic [3:0] junk, input int hold, input int abort);
    logic [3:0]  cs, ds;
    logic [14:0] idl, sst, dat, endx;
    cs   = lowest(sel);
    idl  = snap(3'd0, 4'h0, 1'b0, 1'b0);
    sst  = snap(3'd1, cs, 1'b0, 1'b0);
    dat  = snap(3'd2, cs, 1'b0, 1'b0);
    endx = snap(3'd4, cs, 1'b1, 1'b0);
    push(1'b0, 1'b1, sel, rd, 4'hF, 4'h0, sst, sst);
    if (abort == 1) begin
      push(1'b0, 1'b0, sel, rd, 4'hF, 4'h0, idl, idl);
      return;
    end
    for (int i = 1; i < ds_wait; i++) push(1'b0, 1'b1, sel, rd, 4'hF, 4'h0, sst, sst);
    ds = rd ? 4'hF : 4'($urandom_range(0, 14));
    push(1'b0, 1'b1, sel, rd, ds, 4'h0, dat, dat);
    for (int i = 0; i < ack_wait; i++) push(1'b0, 1'b1, sel, rd, ds, junk, dat, dat);
    if (abort == 2) begin
      push(1'b0, 1'b0, sel, rd, ds, cs | junk, idl, idl);
      push(1'b0, 1'b0, sel, rd, ds, cs, idl, idl);
      return;
    end
    push(1'b0, 1'b1, sel, rd, ds, cs | junk, endx, snap(3'd3, cs, 1'b0, 1'b0));
    if (abort == 3) begin
      push(1'b0, 1'b0, sel, rd, ds, 4'h0, idl, idl);
      return;
    end
    for (int n = 1; n <= D3 + hold; n++)
      push(1'b0, 1'b1, sel, rd, ds, 4'($urandom), endx, (n >= D3) ? endx : snap(3'd3, cs, 1'b0, 1'b0));
    push(1'b0, 1'b0, sel, rd, ds, 4'h0, idl, idl);
  endtask

  task automatic test_reset();
    RESET = 1'b1; bfcs = 1'b1; match = 1'b1; validspace = 1'b1; READ = 1'b1;
    DS_n = 4'h0; region_sel = 4'hF; region_ack = 4'hF;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if (obs0 !== 15'h0) $display("FAIL reset d0 got %h want %h", obs0, 15'h0); else n_pass++;
    n_total++;
    if (obs3 !== 15'h0) $display("FAIL reset d3 got %h want %h", obs3, 15'h0); else n_pass++;
    RESET = 1'b0; bfcs = 1'b0; region_ack = 4'h0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_idle_hold();
    for (int k = 0; k < 4; k++) begin
      bfcs = (k != 3); match = (k != 0); validspace = (k != 1);
      region_sel = (k == 2) ? 4'h0 : 4'($urandom_range(1, 15));
      READ = 1'b1; DS_n = 4'h0; region_ack = 4'($urandom);
      repeat (2) @(posedge CLK);
      #1;
      n_total++;
      if (obs0 !== 15'h0) $display("FAIL idle_hold%0d d0 got %h want %h", k, obs0, 15'h0); else n_pass++;
      n_total++;
      if (obs3 !== 15'h0) $display("FAIL idle_hold%0d d3 got %h want %h", k, obs3, 15'h0); else n_pass++;
    end
    bfcs = 1'b0; match = 1'b1; validspace = 1'b1; region_ack = 4'h0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_transactions();
    int ab;
    build_txn(4'b0100, 1'b1, 1, 3, 4'h0, 1, 0);
    build_txn(4'b0100, 1'b0, 5, 2, 4'h0, 0, 0);
    build_txn(4'b1010, 1'b0, 1, 2, 4'b1000, 0, 0);
    build_txn(4'b0110, 1'b1, 1, 1, 4'h0, 0, 2);
    build_txn(4'b1000, 1'b0, 2, 0, 4'h0, 0, 1);
    build_txn(4'b0011, 1'b1, 1, 0, 4'h0, 2, 3);
    for (int t = 0; t < 40; t++) begin
      logic [3:0] sel;
      logic       rd;
      sel = 4'($urandom_range(1, 15));
      rd  = 1'($urandom);
      ab  = $urandom_range(0, 7);
      build_txn(sel, rd, rd ? 1 : $urandom_range(1, 4), $urandom_range(0, 5),
                4'($urandom) & ~lowest(sel), $urandom_range(0, 2), (ab > 3) ? 0 : ab);
    end
    foreach (tl[i]) begin
      RESET = tl[i].rst; bfcs = tl[i].b; region_sel = tl[i].sel; READ = tl[i].rd;
      DS_n = tl[i].ds; region_ack = tl[i].ack;
      @(posedge CLK);
      #1;
      n_total++;
      if (obs0 !== tl[i].e0) $display("FAIL txn step%0d d0 got %h want %h", i, obs0, tl[i].e0); else n_pass++;
      n_total++;
      if (obs3 !== tl[i].e3) $display("FAIL txn step%0d d3 got %h want %h", i, obs3, tl[i].e3); else n_pass++;
    end
    tl.delete();
  endtask

  task automatic test_timeout_reset();
    logic [14:0] idl, sst, dat;
    idl = snap(3'd0, 4'h0, 1'b0, 1'b0);
    sst = snap(3'd1, 4'b0001, 1'b0, 1'b0);
    dat = snap(3'd2, 4'b0001, 1'b0, 1'b0);
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, sst, sst);
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, dat, dat);
    for (int i = 0; i < TO - 1; i++) push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'b1110, dat, dat);
`ifdef Z3_SLAVE_TIMEOUT_EN
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, snap(3'd4, 4'b0001, 1'b1, 1'b1), snap(3'd4, 4'b0001, 1'b1, 1'b1));
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, snap(3'd4, 4'b0001, 1'b1, 1'b1), snap(3'd4, 4'b0001, 1'b1, 1'b1));
    push(1'b1, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, idl, idl);
    push(1'b0, 1'b0, 4'b0001, 1'b1, 4'hF, 4'h0, idl, idl);
    // Selected ack on the expiry cycle takes the normal path.
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, sst, sst);
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, dat, dat);
    for (int i = 0; i < TO - 1; i++) push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, dat, dat);
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'b0001, snap(3'd4, 4'b0001, 1'b1, 1'b0), snap(3'd3, 4'b0001, 1'b0, 1'b0));
    push(1'b0, 1'b0, 4'b0001, 1'b1, 4'hF, 4'h0, idl, idl);
`else
    for (int i = 0; i < 5; i++) push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, dat, dat);
    push(1'b0, 1'b1, 4'b0001, 1'b1, 4'hF, 4'b0001, snap(3'd4, 4'b0001, 1'b1, 1'b0), snap(3'd3, 4'b0001, 1'b0, 1'b0));
    push(1'b1, 1'b1, 4'b0001, 1'b1, 4'hF, 4'h0, idl, idl);
    push(1'b0, 1'b0, 4'b0001, 1'b1, 4'hF, 4'h0, idl, idl);
`endif
    foreach (tl[i]) begin
      RESET = tl[i].rst; bfcs = tl[i].b; region_sel = tl[i].sel; READ = tl[i].rd;
      DS_n = tl[i].ds; region_ack = tl[i].ack;
      @(posedge CLK);
      #1;
      n_total++;
      if (obs0 !== tl[i].e0) $display("FAIL timeout step%0d d0 got %h want %h", i, obs0, tl[i].e0); else n_pass++;
      n_total++;
      if (obs3 !== tl[i].e3) $display("FAIL timeout step%0d d3 got %h want %h", i, obs3, tl[i].e3); else n_pass++;
    end
    tl.delete();
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_transactions();
    test_timeout_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
